// File: rtl/axis_delay_sequencer.sv
// Sequencer for a BRAM-backed AXI4-Stream delay line: circular addressing,
// priming, flush on delay change and a 2-entry skid buffer for backpressure.
module axis_delay_sequencer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH  = 10
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_delay,
  output logic                        sts_primed,
  output logic [BRAM_ADDR_WIDTH-1:0]  sts_fill,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        bram_porta_clk,
  output logic                        bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
  output logic [AXIS_TDATA_WIDTH-1:0] bram_porta_wrdata,
  output logic                        bram_porta_we,
  output logic                        bram_portb_clk,
  output logic                        bram_portb_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_portb_addr,
  input  logic [AXIS_TDATA_WIDTH-1:0] bram_portb_rddata
);

  localparam int AW = BRAM_ADDR_WIDTH;
  localparam int DW = AXIS_TDATA_WIDTH;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] delay_reg, delay_nxt;
  logic [AW-1:0] fill_cnt, fill_nxt, fill_inc;
  logic [1:0]    buf_cnt, buf_cnt_nxt;
  logic          rd_inflight, rd_inflight_nxt;
  logic [DW-1:0] buf0, buf1;
  logic          accept, pop, push, flush;
  logic [2:0]    occ;

  // Buffer head drives the master side; a returning read is pushed the cycle after issue
  assign m_axis_tvalid = (buf_cnt != 2'd0);
  assign m_axis_tdata  = m_axis_tvalid ? buf0 : '0;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign push          = rd_inflight;
  assign fill_inc      = fill_cnt + AW'(1);

  // Occupancy after this cycle's pop and pending push, used to throttle the slave side
  assign occ = {1'b0, buf_cnt} + {2'b00, rd_inflight} - {2'b00, pop};

  assign sts_primed        = (state == RUN);
  assign sts_fill          = fill_cnt;
  assign bram_porta_clk    = aclk;
  assign bram_porta_rst    = areset;
  assign bram_porta_addr   = wr_ptr;
  assign bram_porta_wrdata = s_axis_tdata;
  assign bram_porta_we     = accept;
  assign bram_portb_clk    = aclk;
  assign bram_portb_rst    = areset;
  assign bram_portb_addr   = (state == RUN) ? (wr_ptr - delay_reg) : '0;

  // Next-state, slave ready and bookkeeping for fill count, delay and skid buffer
  always_comb begin
    state_nxt       = state;
    delay_nxt       = delay_reg;
    fill_nxt        = fill_cnt;
    flush           = 1'b0;
    s_axis_tready   = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_delay != '0) begin
          delay_nxt = cfg_delay;
          fill_nxt  = '0;
          state_nxt = FILL;
        end
      end
      FILL:    s_axis_tready = 1'b1;
      RUN:     s_axis_tready = (occ < 3'd2);
      default: state_nxt = IDLE;
    endcase
    accept = s_axis_tvalid && s_axis_tready;

    if ((state == FILL) && accept) begin
      fill_nxt = fill_inc;
      if (fill_inc == delay_reg) state_nxt = RUN;
    end

    // A delay change overrides everything; a beat accepted now becomes fill beat 0
    // of the new delay, which for a delay of 1 already completes priming.
    if ((state != IDLE) && (cfg_delay != delay_reg)) begin
      flush     = 1'b1;
      delay_nxt = cfg_delay;
      if (cfg_delay == '0) begin
        fill_nxt  = '0;
        state_nxt = IDLE;
      end else begin
        fill_nxt  = accept ? AW'(1) : '0;
        state_nxt = (accept && (cfg_delay == AW'(1))) ? RUN : FILL;
      end
    end

    rd_inflight_nxt = !flush && (state == RUN) && accept;
    buf_cnt_nxt     = flush ? 2'd0 : (buf_cnt + {1'b0, push} - {1'b0, pop});
  end

  // Control registers: state, pointers, counters and buffer occupancy
  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      delay_reg   <= '0;
      fill_cnt    <= '0;
      buf_cnt     <= 2'd0;
      rd_inflight <= 1'b0;
    end else begin
      state       <= state_nxt;
      delay_reg   <= delay_nxt;
      fill_cnt    <= fill_nxt;
      buf_cnt     <= buf_cnt_nxt;
      rd_inflight <= rd_inflight_nxt;
      if (accept) wr_ptr <= wr_ptr + AW'(1);
    end
  end

  // Skid buffer data: entries are only meaningful below buf_cnt, so no reset needed
  always_ff @(posedge aclk) begin
    case ({push, pop})
      2'b10: begin
        if (buf_cnt == 2'd0) buf0 <= bram_portb_rddata;
        else                 buf1 <= bram_portb_rddata;
      end
      2'b01: buf0 <= buf1;
      2'b11: begin
        if (buf_cnt == 2'd1) begin
          buf0 <= bram_portb_rddata;
        end else begin
          buf0 <= buf1;
          buf1 <= bram_portb_rddata;
        end
      end
      default: ;
    endcase
  end

endmodule
